// File: rtl/multiword_adder_seq.sv
// multiword_adder_seq: adds two WORDS x WIDTH-bit operands one word per clock through a
// single ripple_carry_adder. Define MULTIWORD_ADDER_SUB_EN to add the `sub` (A-B) input.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module ripple_carry_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             carry_in,
    output logic [WIDTH-1:0] z,
    output logic             carry_out
);
    logic [WIDTH:0] c;

    assign c[0] = carry_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        full_adder u_fa (
            .a    (x[i]),
            .b    (y[i]),
            .cin  (c[i]),
            .s    (z[i]),
            .cout (c[i+1])
        );
    end

    assign carry_out = c[WIDTH];
endmodule

// Handshake: `start` is a request sampled only in IDLE; there is no ready signal, a start
// seen while busy or done is dropped. `done` is a one-cycle result-valid pulse.
module multiword_adder_seq #(
    parameter int WIDTH = 8,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [WIDTH*WORDS-1:0] a_in,
    input  logic [WIDTH*WORDS-1:0] b_in,
    input  logic                   carry_in,
`ifdef MULTIWORD_ADDER_SUB_EN
    input  logic                   sub,
`endif
    output logic [WIDTH*WORDS-1:0] sum_out,
    output logic                   carry_out,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             state_dbg
);
    localparam int TOTAL = WIDTH * WORDS;
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [TOTAL-1:0] a_q;
    logic [TOTAL-1:0] b_q;
    logic             carry_q;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic [TOTAL-1:0] b_load;
    logic             carry_load;
    logic [WIDTH-1:0] word_a;
    logic [WIDTH-1:0] word_b;
    logic [WIDTH-1:0] word_z;
    logic             word_carry;

    assign accept = (state == IDLE) && start;

`ifdef MULTIWORD_ADDER_SUB_EN
    // A - B is A + ~B + 1, so the borrow-free case shows up as carry_out = 1.
    assign b_load     = sub ? ~b_in : b_in;
    assign carry_load = sub ? 1'b1  : carry_in;
`else
    assign b_load     = b_in;
    assign carry_load = carry_in;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (idx == LAST_IDX) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign state_dbg = state;

    assign word_a = a_q[idx*WIDTH +: WIDTH];
    assign word_b = b_q[idx*WIDTH +: WIDTH];

    ripple_carry_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .x         (word_a),
        .y         (word_b),
        .carry_in  (carry_q),
        .z         (word_z),
        .carry_out (word_carry)
    );

    // Operands are captured once at the start edge; sum_out is only touched in RUN so it
    // holds the finished result from DONE until the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx     <= '0;
            sum_out <= '0;
        end else if (accept) begin
            a_q     <= a_in;
            b_q     <= b_load;
            carry_q <= carry_load;
            idx     <= '0;
        end else if (state == RUN) begin
            sum_out[idx*WIDTH +: WIDTH] <= word_z;
            carry_q                     <= word_carry;
            if (idx != LAST_IDX) begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign carry_out = carry_q;
endmodule
